// File: rtl/usb_uart_pkg.sv
// ---------------------------------------------------------------------------
// usb_uart_pkg
// Shared definitions for the USB UART transmit-side arbiter.
//   - State encoding for the arbiter FSM (IDLE, TAG, BURST).
//   - TAG_PREFIX: upper nibble of the channel tag byte.
//   - CNT_W: width of the burst and idle counters.
// ---------------------------------------------------------------------------
package usb_uart_pkg;

    localparam int CNT_W = 8;

    localparam logic [3:0] TAG_PREFIX = 4'hA;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TAG   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        TAG   = ST_TAG,
        BURST = ST_BURST
    } state_t;

endpackage

// File: rtl/usb_rr_pick.sv
// ---------------------------------------------------------------------------
// usb_rr_pick
// Combinational round-robin picker. Searches req upward starting at last+1
// (modulo NUM_REQ) and reports the first set bit.
// Ports:
//   req    - request vector, one bit per requester
//   last   - index of the previous winner
//   found  - at least one request is set
//   onehot - one-hot winner (zero when nothing found)
//   idx    - binary index of the winner (zero when nothing found)
// ---------------------------------------------------------------------------
module usb_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic                       found,
    output logic [NUM_REQ-1:0]         onehot,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets from farthest to nearest so the nearest requester after
    // 'last' is the one left standing when the loop finishes.
    always_comb begin
        found    = 1'b0;
        onehot   = '0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand     = (int'(last) + off) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (req[cand_idx]) begin
                found            = 1'b1;
                idx              = cand_idx;
                onehot           = '0;
                onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// usb_uart_tx_arbiter
// Shares the device-to-host byte pipe of the USB UART between NUM_REQ byte
// streams. Round-robin grant, held for a burst that ends after MAX_BURST
// accepted bytes or IDLE_TIMEOUT consecutive cycles of the owner idling.
// Optional build macro USB_UART_ARB_TAG_EN inserts a channel tag byte
// ({TAG_PREFIX, index}) before a burst whose owner differs from the last
// tagged channel.
// Ports:
//   clk_48mhz     - system clock
//   reset_n       - asynchronous active-low reset
//   req_data      - requester bytes, requester i on [8i+7:8i]
//   req_valid     - per-requester valid
//   req_ready     - per-requester ready (only the owner can see ready)
//   uart_in_data  - byte to usb_uart
//   uart_in_valid - valid to usb_uart
//   uart_in_ready - ready from usb_uart
//   grant         - one-hot current owner, zero when idle
//   busy          - high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module usb_uart_tx_arbiter
    import usb_uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                 clk_48mhz,
    input  logic                 reset_n,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_in_data,
    output logic                 uart_in_valid,
    input  logic                 uart_in_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int               IDX_W      = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
    logic [IDX_W-1:0]   last_idx_reg, last_idx_next;
    logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
    logic [CNT_W-1:0]   idle_cnt_reg, idle_cnt_next;
`ifdef USB_UART_ARB_TAG_EN
    logic               tag_valid_reg, tag_valid_next;
    logic [IDX_W-1:0]   tag_idx_reg, tag_idx_next;
`endif

    logic [7:0]         req_bytes [NUM_REQ];
    logic               pick_found;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               cur_valid;
    logic               cur_xfer;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    usb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .last   (last_idx_reg),
        .found  (pick_found),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign cur_valid = req_valid[grant_idx_reg];
    assign cur_xfer  = (state_reg == BURST) && cur_valid && uart_in_ready;

    assign grant = grant_reg;
    assign busy  = (state_reg != IDLE);

    // Output side is purely a function of state, so reset clears it at once.
    always_comb begin
        uart_in_data  = '0;
        uart_in_valid = 1'b0;
        req_ready     = '0;
        case (state_reg)
            BURST: begin
                uart_in_data             = req_bytes[grant_idx_reg];
                uart_in_valid            = cur_valid;
                req_ready[grant_idx_reg] = uart_in_ready;
            end
`ifdef USB_UART_ARB_TAG_EN
            TAG: begin
                uart_in_data  = {TAG_PREFIX, 4'(grant_idx_reg)};
                uart_in_valid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        grant_idx_next = grant_idx_reg;
        last_idx_next  = last_idx_reg;
        burst_cnt_next = burst_cnt_reg;
        idle_cnt_next  = idle_cnt_reg;
`ifdef USB_UART_ARB_TAG_EN
        tag_valid_next = tag_valid_reg;
        tag_idx_next   = tag_idx_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next     = pick_onehot;
                    grant_idx_next = pick_idx;
                    last_idx_next  = pick_idx;
                    burst_cnt_next = '0;
                    idle_cnt_next  = '0;
`ifdef USB_UART_ARB_TAG_EN
                    if (!tag_valid_reg || (tag_idx_reg != pick_idx)) begin
                        state_next = TAG;
                    end else begin
                        state_next = BURST;
                    end
`else
                    state_next = BURST;
`endif
                end
            end
`ifdef USB_UART_ARB_TAG_EN
            TAG: begin
                // Tag byte is not part of the burst count.
                if (uart_in_ready) begin
                    tag_valid_next = 1'b1;
                    tag_idx_next   = grant_idx_reg;
                    state_next     = BURST;
                end
            end
`endif
            BURST: begin
                if (cur_xfer) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                end
                if (cur_valid) begin
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
                // Either limit ends the burst; both at once still exit once.
                if ((cur_xfer && (burst_cnt_reg == BURST_LAST)) ||
                    (!cur_valid && (idle_cnt_reg == IDLE_LAST))) begin
                    state_next     = IDLE;
                    grant_next     = '0;
                    burst_cnt_next = '0;
                    idle_cnt_next  = '0;
                end
            end
            default: begin
                state_next     = IDLE;
                grant_next     = '0;
                burst_cnt_next = '0;
                idle_cnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            // Requester 0 gets first pick after reset.
            last_idx_reg  <= IDX_W'(NUM_REQ - 1);
            burst_cnt_reg <= '0;
            idle_cnt_reg  <= '0;
`ifdef USB_UART_ARB_TAG_EN
            tag_valid_reg <= 1'b0;
            tag_idx_reg   <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            grant_idx_reg <= grant_idx_next;
            last_idx_reg  <= last_idx_next;
            burst_cnt_reg <= burst_cnt_next;
            idle_cnt_reg  <= idle_cnt_next;
`ifdef USB_UART_ARB_TAG_EN
            tag_valid_reg <= tag_valid_next;
            tag_idx_reg   <= tag_idx_next;
`endif
        end
    end

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_usb_uart_tx_arbiter
// Bench for usb_uart_tx_arbiter. Requester byte sources are small FIFOs; each
// expected {grant, byte} pair is queued when stimulus is loaded and compared
// when the arbiter hands a byte to usb_uart. A second instance runs with
// MAX_BURST=1. Honors USB_UART_ARB_TAG_EN when defined.
// ---------------------------------------------------------------------------
module tb_usb_uart_tx_arbiter;

    logic        clk_48mhz = 1'b0;
    logic        reset_n   = 1'b0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [7:0]  uart_in_data;
    logic        uart_in_valid;
    logic        uart_in_ready = 1'b0;
    logic [3:0]  grant;
    logic        busy;

    logic [31:0] req_data2      = 32'h0000_1110;
    logic [3:0]  req_valid2     = '0;
    logic [3:0]  req_ready2;
    logic [7:0]  uart_in_data2;
    logic        uart_in_valid2;
    logic        uart_in_ready2 = 1'b1;
    logic [3:0]  grant2;
    logic        busy2;

    always #10 clk_48mhz = ~clk_48mhz;

    usb_uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(64), .IDLE_TIMEOUT(16)) dut (
        .clk_48mhz     (clk_48mhz),
        .reset_n       (reset_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .uart_in_data  (uart_in_data),
        .uart_in_valid (uart_in_valid),
        .uart_in_ready (uart_in_ready),
        .grant         (grant),
        .busy          (busy)
    );

    usb_uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(1), .IDLE_TIMEOUT(16)) dut_mb1 (
        .clk_48mhz     (clk_48mhz),
        .reset_n       (reset_n),
        .req_data      (req_data2),
        .req_valid     (req_valid2),
        .req_ready     (req_ready2),
        .uart_in_data  (uart_in_data2),
        .uart_in_valid (uart_in_valid2),
        .uart_in_ready (uart_in_ready2),
        .grant         (grant2),
        .busy          (busy2)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  src_mem [4][256];
    int          src_rd [4];
    int          src_wr [4];
    logic [11:0] exp_q [$];
    logic [11:0] exp2_q [$];
    int          tb_tag_last = -1;
    bit          gap_en = 1'b0;
    bit          en2    = 1'b0;
    logic [3:0]  prev_grant = '0;
    int          idle_run = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_src(input int i, input logic [7:0] b);
        src_mem[i][src_wr[i]] = b;
        src_wr[i]++;
    endtask

    task automatic push_exp(input int i, input logic [7:0] b);
        logic [3:0] g;
        g = 4'(1 << i);
        exp_q.push_back({g, b});
    endtask

    // Expected tag byte when a grant goes to a channel other than the last tagged one.
    task automatic begin_grant(input int i);
`ifdef USB_UART_ARB_TAG_EN
        if (tb_tag_last != i) push_exp(i, {4'hA, 4'(i)});
`endif
        tb_tag_last = i;
    endtask

    task automatic send(input int i, input int n, input logic [7:0] base);
        logic [7:0] b;
        begin_grant(i);
        for (int k = 0; k < n; k++) begin
            b = base + 8'(k);
            push_src(i, b);
            push_exp(i, b);
        end
    endtask

    task automatic wait_exp_le(input string tag, input int lim, input int budget);
        int t;
        t = 0;
        while (exp_q.size() > lim && t < budget) begin
            @(posedge clk_48mhz); #2;
            t++;
        end
        if (exp_q.size() > lim) begin
            check_eq(tag, exp_q.size(), lim);
            exp_q.delete();
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            @(posedge clk_48mhz); #2;
            t++;
        end
        if (busy) check_eq(tag, busy, 0);
    endtask

    // Requester sources: present the FIFO head just after each rising edge.
    always @(posedge clk_48mhz) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = src_mem[i][src_rd[i]];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Monitor: a handshake seen here completes on the coming rising edge.
    always @(negedge clk_48mhz) begin
        if (uart_in_valid && uart_in_ready) begin
            $display("%0t xfer grant=%b data=%02h", $time, grant, uart_in_data);
            if (exp_q.size() == 0) check_eq("xfer_unexpected", exp_q.size(), 1);
            else check_eq("xfer", {grant, uart_in_data}, exp_q.pop_front());
            if (gap_en && prev_grant != 4'b0 && grant != prev_grant)
                check_eq("bubble_len", idle_run, 1);
            prev_grant = grant;
            idle_run   = 0;
        end else begin
            idle_run++;
            if (gap_en && grant == 4'b0) check_eq("bubble_valid", uart_in_valid, 0);
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) src_rd[i]++;
        end
        if (en2 && uart_in_valid2 && uart_in_ready2) begin
            $display("%0t xfer2 grant=%b data=%02h", $time, grant2, uart_in_data2);
            if (exp2_q.size() > 0) check_eq("mb1_xfer", {grant2, uart_in_data2}, exp2_q.pop_front());
            if (exp2_q.size() == 0) en2 = 1'b0;
        end
    end

    initial begin
        int order [5];
        int cnt;
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end

        // Reset state
        repeat (3) @(posedge clk_48mhz);
        #2;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", uart_in_valid, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_data", uart_in_data, 0);
        check_eq("rst_ready2", req_ready2, 0);
        reset_n       = 1'b1;
        uart_in_ready = 1'b1;
        @(posedge clk_48mhz); #2;

        // All four requesters busy: 0,1,2,3,0 with 64-byte bursts
        gap_en     = 1'b1;
        prev_grant = '0;
        for (int n = 0; n < 5; n++) begin
            begin_grant(order[n]);
            for (int k = 0; k < 64; k++) begin
                push_src(order[n], 8'((order[n] << 6) | k));
                push_exp(order[n], 8'((order[n] << 6) | k));
            end
        end
        wait_exp_le("rr_drain", 0, 2000);
        gap_en = 1'b0;
        wait_idle("rr_idle", 100);

        // Requester 2 alone: 5 bytes then idle timeout
        send(2, 5, 8'h20);
        wait_exp_le("solo_drain", 0, 200);
        cnt = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk_48mhz);
            if (grant == 4'b0100) cnt++;
            else break;
        end
        check_eq("idle_hold", cnt, 16);
        check_eq("idle_grant", grant, 0);
        check_eq("idle_busy", busy, 0);
        @(posedge clk_48mhz); #2;

        // Stall with uart_in_ready low for 100 cycles
        send(1, 20, 8'h40);
        wait_exp_le("stall_pre", 15, 200);
        uart_in_ready = 1'b0;
        repeat (100) @(negedge clk_48mhz);
        check_eq("stall_grant", grant, 4'b0010);
        check_eq("stall_valid", uart_in_valid, 1);
        check_eq("stall_data", uart_in_data, exp_q[0][7:0]);
        check_eq("stall_busy", busy, 1);
        @(posedge clk_48mhz); #2;
        uart_in_ready = 1'b1;
        wait_exp_le("stall_drain", 0, 200);
        wait_idle("stall_idle", 100);

        // Asynchronous reset mid-burst
        send(1, 40, 8'h60);
        wait_exp_le("mid_pre", 30, 200);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("mid_grant", grant, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_valid", uart_in_valid, 0);
        check_eq("mid_ready", req_ready, 0);
        check_eq("mid_data", uart_in_data, 0);
        for (int i = 0; i < 4; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        exp_q.delete();
        tb_tag_last = -1;
        repeat (2) @(posedge clk_48mhz);
        #2;
        reset_n = 1'b1;
        send(0, 3, 8'h01);
        send(3, 3, 8'h31);
        wait_exp_le("post_rst_drain", 0, 300);
        wait_idle("post_rst_idle", 100);

        // Channel switches, then a repeat grant to the same channel
        send(1, 2, 8'h51);
        wait_exp_le("sw1_drain", 0, 100);
        wait_idle("sw1_idle", 100);
        send(3, 2, 8'h71);
        wait_exp_le("sw3_drain", 0, 100);
        wait_idle("sw3_idle", 100);
        send(3, 2, 8'h73);
        wait_exp_le("sw3b_drain", 0, 100);
        wait_idle("sw3b_idle", 100);

        // MAX_BURST=1 instance with requesters 0 and 1 always valid
        for (int n = 0; n < 4; n++) begin
`ifdef USB_UART_ARB_TAG_EN
            exp2_q.push_back({4'(1 << (n % 2)), 4'hA, 4'(n % 2)});
`endif
            exp2_q.push_back({4'(1 << (n % 2)), 8'(8'h10 + (n % 2))});
        end
        en2        = 1'b1;
        req_valid2 = 4'b0011;
        cnt = 0;
        while (exp2_q.size() > 0 && cnt < 100) begin
            @(posedge clk_48mhz); #2;
            cnt++;
        end
        if (exp2_q.size() > 0) check_eq("mb1_drain", exp2_q.size(), 0);
        en2        = 1'b0;
        req_valid2 = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
